// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the four-lane sample-capture
// sequencer (capture_sched) and its MCU read port (mcu_rd_port).
// Contents: the sequencer state enum, lane-counter width and lane count,
// and the lane-index constants that select each lane in the write mux.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;

    // The lane index is also the upper field of the RAM address.
    localparam logic [LANE_W-1:0] LANE_A1 = 2'd0;
    localparam logic [LANE_W-1:0] LANE_A2 = 2'd1;
    localparam logic [LANE_W-1:0] LANE_B1 = 2'd2;
    localparam logic [LANE_W-1:0] LANE_B2 = 2'd3;

endpackage

// File: rtl/mcu_rd_port.sv
// mcu_rd_port: MCU read path into the sample RAM.
// A request (cs_mem=1, ren=0) is accepted only in DONE and only when no
// rearm arrives in the same cycle. In-range requests strobe the RAM; an
// out-of-range sample index skips the RAM and returns zero. data_tomcu
// updates two edges after the request is sampled, one request per cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   state, rearm      sequencer state and rearm pulse (request qualification)
//   read_addr         MCU address {lane, idx}
//   ren, cs_mem       MCU read enable (active-low), chip select (active-high)
//   mem_re, mem_raddr RAM read strobe and address (registered)
//   mem_rdata         RAM read data, valid one cycle after mem_re
//   data_tomcu        read data returned to the MCU (registered)
module mcu_rd_port
    import capture_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int N_SAMPLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  state_t            state,
    input  logic              rearm,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              ren,
    input  logic              cs_mem,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_tomcu
);

    localparam int IDX_W = ADDR_W - LANE_W;
    // One extra bit so N_SAMPLES = 2^IDX_W is representable.
    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_SAMPLES);

    logic rd_req;
    logic in_range;
    logic vld_s1, oor_s1;
    logic vld_s2, oor_s2;

    assign rd_req   = (state == DONE) && cs_mem && !ren && !rearm;
    assign in_range = ({1'b0, read_addr[IDX_W-1:0]} < N_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_re     <= 1'b0;
            mem_raddr  <= '0;
            vld_s1     <= 1'b0;
            oor_s1     <= 1'b0;
            vld_s2     <= 1'b0;
            oor_s2     <= 1'b0;
            data_tomcu <= '0;
        end else begin
            mem_re <= rd_req && in_range;
            if (rd_req) begin
                mem_raddr <= read_addr;
            end
            vld_s1 <= rd_req;
            oor_s1 <= !in_range;
            vld_s2 <= vld_s1;
            oor_s2 <= oor_s1;
            if (vld_s2) begin
                data_tomcu <= oor_s2 ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: rtl/capture_sched.sv
// capture_sched: capture sequencer for the four-lane sample datapath.
// Captures N_SAMPLES sample sets into the single-write-port sample RAM
// (one lane per cycle, address {lane, idx}), raises done, then serves MCU
// reads through mcu_rd_port until rearmed.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | held during reset; first write issued on the exit edge
//   CAPTURE | one RAM write per cycle, 4-cycle slot per sample set
//   DONE    | no writes; MCU reads served; rearm restarts the capture
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   dina1..dinb2                 lane 0..3 samples
//   rearm                        restart pulse, honoured only in DONE
//   read_addr, ren, cs_mem       MCU read request
//   mem_we/mem_waddr/mem_wdata   RAM write port
//   mem_re/mem_raddr/mem_rdata   RAM read port
//   data_tomcu                   read data to MCU
//   done                         capture complete
//   test_addr, testcycle(1)      debug: last write address, idx, lane
module capture_sched
    import capture_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int N_SAMPLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   dina1,
    input  logic [DATA_W-1:0]   dina2,
    input  logic [DATA_W-1:0]   dinb1,
    input  logic [DATA_W-1:0]   dinb2,
    input  logic                rearm,
    input  logic [ADDR_W-1:0]   read_addr,
    input  logic                ren,
    input  logic                cs_mem,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_re,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   data_tomcu,
    output logic                done,
    output logic [ADDR_W-1:0]   test_addr,
    output logic [ADDR_W-3:0]   testcycle,
    output logic [1:0]          testcycle1
);

    localparam int IDX_W = ADDR_W - LANE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    state_t            state, state_nxt;
    logic [LANE_W-1:0] lane_q, lane_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [DATA_W-1:0] hold_a2, hold_b1, hold_b2;
    logic              wr_now;
    logic [LANE_W-1:0] wr_lane;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The write issued on an edge uses the counters as they stand; IDLE exit
    // and rearm both start from lane 0 / idx 0 so the first write lands on
    // the very edge that leaves IDLE or DONE.
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane_q;
        idx_nxt   = idx_q;
        wr_now    = 1'b0;
        wr_lane   = lane_q;
        wr_idx    = idx_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                wr_now  = 1'b1;
                wr_lane = LANE_A1;
                wr_idx  = '0;
            end
            CAPTURE: begin
                wr_now = 1'b1;
            end
            DONE: begin
                done_nxt = 1'b1;
                if (rearm) begin
                    wr_now   = 1'b1;
                    wr_lane  = LANE_A1;
                    wr_idx   = '0;
                    done_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (wr_now) begin
            if (wr_lane == LANE_B2) begin
                lane_nxt  = LANE_A1;
                idx_nxt   = wr_idx + IDX_W'(1);
                state_nxt = (wr_idx == LAST_IDX) ? DONE : CAPTURE;
            end else begin
                lane_nxt  = wr_lane + LANE_W'(1);
                idx_nxt   = wr_idx;
                state_nxt = CAPTURE;
            end
        end
    end

    // Lane 0 goes straight from the input; lanes 1..3 come from the
    // holding registers so the whole set is from one cycle.
    always_comb begin
        wr_data = dina1;
        case (wr_lane)
            LANE_A1: wr_data = dina1;
            LANE_A2: wr_data = hold_a2;
            LANE_B1: wr_data = hold_b1;
            default: wr_data = hold_b2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q    <= '0;
            idx_q     <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            hold_a2   <= '0;
            hold_b1   <= '0;
            hold_b2   <= '0;
        end else begin
            lane_q <= lane_nxt;
            idx_q  <= idx_nxt;
            mem_we <= wr_now;
            done   <= done_nxt;
            if (wr_now) begin
                mem_waddr <= {wr_lane, wr_idx};
                mem_wdata <= wr_data;
            end
            if (wr_now && (wr_lane == LANE_A1)) begin
                hold_a2 <= dina2;
                hold_b1 <= dinb1;
                hold_b2 <= dinb2;
            end
        end
    end

    assign test_addr  = mem_waddr;
    assign testcycle  = idx_q;
    assign testcycle1 = lane_q;

    mcu_rd_port #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .N_SAMPLES (N_SAMPLES)
    ) u_rd_port (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .rearm      (rearm),
        .read_addr  (read_addr),
        .ren        (ren),
        .cs_mem     (cs_mem),
        .mem_re     (mem_re),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .data_tomcu (data_tomcu)
    );

endmodule
